fidmas_wb: RTL and testbench
============================

# fidmas_wb

Writeback buffer that sits directly downstream of the combinational `fidmas` integer/float ALU. It captures each ALU result together with its opcode context and derived status flags into a small in-order FIFO. It presents the results to the register-file/writeback consumer over a valid/ready handshake. This decouples the ALU issue rate from consumer stalls and adds one registered stage after the ALU's long combinational path.

## Interface
- `N`, 32: ALU data width; must match the ALU instance.
- `DEPTH`, 4: number of FIFO entries; power of two, 2 to 16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  ALU result valid this cycle.
- `in_ready`  out  1  buffer can accept a result this cycle.
- `in_car`  in  1  ALU `car` output.
- `in_outh`  in  N  ALU `outh` output.
- `in_out`  in  N  ALU `out` output.
- `in_s`  in  2  opcode the result was computed with.
- `in_float`  in  1  float/integer mode the result was computed with.
- `flush`  in  1  synchronous discard of all entries.
- `wb_valid`  out  1  head entry available.
- `wb_ready`  in  1  consumer takes head entry this cycle.
- `wb_car`, `wb_outh`, `wb_out`, `wb_s`, `wb_float`  out  1/N/N/2/1  head entry fields.
- `wb_zero`  out  1  head zero flag.
- `wb_neg`  out  1  head negative flag.
- `level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Push:** a push occurs when `in_valid && in_ready`. The entry stores the input fields plus the flags computed at push time.
- **Pop:** a pop occurs when `wb_valid && wb_ready`. The head advances.
- **Flag rules (evaluated on the pushed values):**
  - Integer mul/div (`in_float=0`, `in_s[1]=1`): `zero = (in_outh==0 && in_out==0)`, `neg = in_outh[N-1]`.
  - Integer add/sub (`in_float=0`, `in_s[1]=0`): `zero = (in_out==0)`, `neg = in_out[N-1]`. `car` is carried but not folded into the flags.
  - Float: `zero = (in_out[N-2:0]==0)`, so ±0 both report zero. `neg = in_out[N-1]`.
  - Integer add/sub entries store `in_outh` as-is. The consumer ignores it for those ops.
- **Ready:** `in_ready = (level < DEPTH)`. It depends only on registered state, so there is no combinational path from `wb_ready` to `in_ready`.
- **Storage:** circular buffer with read and write pointers of `$clog2(DEPTH)` bits. Pointers wrap modulo DEPTH. `level` tracks occupancy explicitly.
- **Occupancy update:**
  - Push only: `level+1`.
  - Pop only: `level-1`.
  - Push and pop together: unchanged. This is legal at any level from 1 to DEPTH-1.
  - At level DEPTH, a push cannot occur because `in_ready=0`. A pop in that cycle frees the slot for the following cycle.
- **Empty:** `wb_valid=0`. The `wb_*` data outputs show the entry at the read pointer (stale or reset contents). The consumer must not rely on them.
- **Flush:** sets `level=0`, and both pointers to 0 on the next edge. Any push or pop in the flush cycle is discarded. Flush has priority over both.
- **Ordering:** results are delivered strictly in push order. No entry is ever dropped except by `flush` or `reset`.

## Timing
- **Reset values:**
  - `wb_valid=0`, `level=0`, `in_ready=1`.
  - Pointers are 0.
  - All storage is 0, so `wb_car`, `wb_outh`, `wb_out`, `wb_s`, `wb_float`, `wb_zero` and `wb_neg` read 0.
- **Reset mid-operation:** all entries are lost immediately, asynchronously, and the outputs return to reset values.
- **Latency:**
  - A push at edge k on an empty buffer gives `wb_valid=1` with that entry's fields after edge k. There is no combinational bypass from `in_*` to `wb_*`.
  - Throughput is one result per cycle when the consumer holds `wb_ready=1`.
- **Output stability:** all `wb_*` outputs are driven from registered state only. While `wb_valid=1` and `wb_ready=0`, they hold stable.
- **Stalls:** `in_valid` may deassert freely; the producer is not required to hold.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with 3 entries queued -> `wb_valid=0`, `level=0`, `in_ready=1`, `wb_out=0` immediately, with no clock edge.
- **Single push:** push integer add `in_out=0`, `in_car=1`, `s=00` -> next cycle `wb_valid=1`, `wb_zero=1`, `wb_car=1`, `wb_neg=0`.
- **Flag rules:**
  - Push integer mul `outh=0xFFFFFFFF`, `out=0x00000000` -> `wb_zero=0`, `wb_neg=1`.
  - Push float `out=0x80000000` -> `wb_zero=1`, `wb_neg=1`.
- **Fill and hold:** with `wb_ready=0`, push 4 entries A..D -> `level=4`, `in_ready=0`, and a fifth `in_valid` is not accepted. Then pulse `wb_ready` for one cycle -> A pops, and the next cycle `in_ready=1`. Draining yields B, C, D in order.
- **Streaming:** hold both valid and ready high for 20 cycles with results 1..20 -> outputs 1..20 appear in order, `level` stays 1, and pointers wrap correctly.
- **Flush:** with `level=3`, assert `flush` together with `in_valid` and `wb_ready` -> next cycle `level=0` and `wb_valid=0`. The flush-cycle input is discarded, and the next push is the first entry delivered.

Source files
------------

// File: rtl/fidmas_wb.sv
`default_nettype none
// ============================================================================
// Module   : fidmas_wb
// Purpose  : In-order writeback FIFO behind the fidmas ALU; captures results
//            with derived zero/neg flags and presents them via valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module fidmas_wb #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_car,
  input  logic [N-1:0]           in_outh,
  input  logic [N-1:0]           in_out,
  input  logic [1:0]             in_s,
  input  logic                   in_float,
  input  logic                   flush,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic                   wb_car,
  output logic [N-1:0]           wb_outh,
  output logic [N-1:0]           wb_out,
  output logic [1:0]             wb_s,
  output logic                   wb_float,
  output logic                   wb_zero,
  output logic                   wb_neg,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_FULL = LW'(DEPTH);

  typedef struct packed {
    logic         car;
    logic [N-1:0] outh;
    logic [N-1:0] res;
    logic [1:0]   s;
    logic         fl;
    logic         zero;
    logic         neg;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          w_push, w_pop;
  logic          w_zero, w_neg;
  entry_t        w_entry;
  entry_t        w_head;

  assign in_ready = (level_q < C_FULL);
  assign wb_valid = (level_q != '0);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = wb_valid && wb_ready;
  assign level    = level_q;

  // Flags follow the op class: mul/div looks at the high word, float ignores
  // the sign bit for zero so both signed zeros report zero.
  always_comb begin
    w_zero = (in_out == '0);
    w_neg  = in_out[N-1];
    if (in_float) begin
      w_zero = (in_out[N-2:0] == '0);
    end else if (in_s[1]) begin
      w_zero = (in_outh == '0) && (in_out == '0);
      w_neg  = in_outh[N-1];
    end
  end

  always_comb begin
    w_entry      = '0;
    w_entry.car  = in_car;
    w_entry.outh = in_outh;
    w_entry.res  = in_out;
    w_entry.s    = in_s;
    w_entry.fl   = in_float;
    w_entry.zero = w_zero;
    w_entry.neg  = w_neg;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + AW'(1);
      if (w_pop)  rptr_d = rptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_push && !flush) begin
      mem_q[wptr_q] <= w_entry;
    end
  end

  assign w_head   = mem_q[rptr_q];
  assign wb_car   = w_head.car;
  assign wb_outh  = w_head.outh;
  assign wb_out   = w_head.res;
  assign wb_s     = w_head.s;
  assign wb_float = w_head.fl;
  assign wb_zero  = w_head.zero;
  assign wb_neg   = w_head.neg;

endmodule
`default_nettype wire

// File: tb/tb_fidmas_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fidmas_wb
// Purpose  : Self-checking bench for fidmas_wb with a queue reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fidmas_wb;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_car, in_float, flush;
  logic [N-1:0]  in_outh, in_out;
  logic [1:0]    in_s;
  logic          wb_valid, wb_ready, wb_car, wb_float, wb_zero, wb_neg;
  logic [N-1:0]  wb_outh, wb_out;
  logic [1:0]    wb_s;
  logic [LW-1:0] level;
  logic [69:0]   act;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        car;
    logic [31:0] outh;
    logic [31:0] out;
    logic [1:0]  s;
    logic        fl;
    logic        z;
    logic        n;
  } ent_t;

  ent_t q[$];

  fidmas_wb #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_car(in_car),
    .in_outh(in_outh), .in_out(in_out), .in_s(in_s), .in_float(in_float),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_car(wb_car),
    .wb_outh(wb_outh), .wb_out(wb_out), .wb_s(wb_s), .wb_float(wb_float),
    .wb_zero(wb_zero), .wb_neg(wb_neg), .level(level)
  );

  always #5 clk = ~clk;

  assign act = {wb_car, wb_outh, wb_out, wb_s, wb_float, wb_zero, wb_neg};

  function automatic ent_t mk(logic car, logic [31:0] outh, logic [31:0] out,
                              logic [1:0] s, logic fl);
    ent_t e;
    e.car = car; e.outh = outh; e.out = out; e.s = s; e.fl = fl;
    if (fl) begin
      e.z = (out[30:0] == 0);
      e.n = out[31];
    end else if (s[1]) begin
      e.z = (outh == 0) && (out == 0);
      e.n = outh[31];
    end else begin
      e.z = (out == 0);
      e.n = out[31];
    end
    return e;
  endfunction

  function automatic logic [69:0] vec(ent_t e);
    return {e.car, e.outh, e.out, e.s, e.fl, e.z, e.n};
  endfunction

  function automatic ent_t rnd_ent();
    logic [31:0] o, h;
    o = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0) : $urandom;
    h = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    return mk(1'($urandom), h, o, 2'($urandom), 1'($urandom));
  endfunction

  task automatic drive(ent_t e);
    in_valid = 1'b1;
    in_car   = e.car;
    in_outh  = e.outh;
    in_out   = e.out;
    in_s     = e.s;
    in_float = e.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    in_valid = 1'b0; wb_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0;
    in_car = 1'b0; in_outh = '0; in_out = '0; in_s = '0; in_float = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({wb_valid, in_ready, level} !== {1'b0, 1'b1, LW'(0)}) begin
      errors++;
      $display("FAIL reset_ctrl: got valid/ready/level %b/%b/%0d, expected 0/1/0", wb_valid, in_ready, level);
    end
    checks++;
    if (act !== 70'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0", act);
    end
  endtask

  task automatic test_single_push();
    ent_t e;
    clear();
    e = mk(1'b1, 32'h1234_5678, 32'h0, 2'b00, 1'b0);
    drive(e);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({wb_valid, level} !== {1'b1, LW'(1)}) begin
      errors++;
      $display("FAIL single_ctrl: got valid/level %b/%0d, expected 1/1", wb_valid, level);
    end
    checks++;
    if ({wb_zero, wb_car, wb_neg} !== 3'b110 || act !== vec(e)) begin
      errors++;
      $display("FAIL single_data: got %h, expected %h", act, vec(e));
    end
  endtask

  task automatic test_flags();
    ent_t v[6];
    clear();
    v[0] = mk(1'b0, 32'hFFFF_FFFF, 32'h0, 2'b10, 1'b0);
    v[1] = mk(1'b0, 32'h0, 32'h8000_0000, 2'b00, 1'b1);
    v[2] = mk(1'b0, 32'h0, 32'h0000_0000, 2'b01, 1'b1);
    v[3] = mk(1'b0, 32'h0, 32'h3F80_0000, 2'b11, 1'b1);
    v[4] = mk(1'b1, 32'h7, 32'h8000_0000, 2'b01, 1'b0);
    v[5] = mk(1'b0, 32'h0, 32'h0000_0001, 2'b11, 1'b0);
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      tick();
      checks++;
      if (act !== vec(v[i]) || level !== LW'(1)) begin
        errors++;
        $display("FAIL flags_%0d: got %h lvl %0d, expected %h lvl 1", i, act, level, vec(v[i]));
      end
    end
    in_valid = 1'b0;
    tick();
    wb_ready = 1'b0;
    checks++;
    if ({v[0].z, v[0].n, v[1].z, v[1].n} !== 4'b0111) begin
      errors++;
      $display("FAIL flags_model: got %b, expected 0111", {v[0].z, v[0].n, v[1].z, v[1].n});
    end
  endtask

  task automatic test_fill_hold();
    ent_t v[5];
    clear();
    for (int i = 0; i < 5; i++) v[i] = mk(1'($urandom), $urandom, 32'h100 + 32'(i), 2'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(v[i]);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({level, in_ready, wb_valid} !== {LW'(4), 1'b0, 1'b1} || act !== vec(v[0])) begin
      errors++;
      $display("FAIL fill_full: got lvl %0d rdy %b head %h, expected lvl 4 rdy 0 head %h", level, in_ready, act, vec(v[0]));
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++;
    if ({level, in_ready} !== {LW'(3), 1'b1}) begin
      errors++;
      $display("FAIL fill_pop: got lvl %0d rdy %b, expected lvl 3 rdy 1", level, in_ready);
    end
    wb_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (act !== vec(v[i]) || wb_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d: got %h v %b, expected %h", i, act, wb_valid, vec(v[i]));
      end
      tick();
    end
    wb_ready = 1'b0;
    checks++;
    if ({wb_valid, level} !== {1'b0, LW'(0)}) begin
      errors++;
      $display("FAIL drain_empty: got valid/level %b/%0d, expected 0/0", wb_valid, level);
    end
  endtask

  task automatic test_streaming();
    clear();
    wb_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      drive(mk(1'b0, 32'h0, 32'(k), 2'b00, 1'b0));
      tick();
      checks++;
      if (wb_out !== 32'(k) || level !== LW'(1) || wb_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got out %0d lvl %0d, expected out %0d lvl 1", k, wb_out, level, k);
      end
    end
    in_valid = 1'b0;
    tick();
    wb_ready = 1'b0;
    checks++;
    if (level !== LW'(0)) begin
      errors++;
      $display("FAIL stream_end: got lvl %0d, expected 0", level);
    end
  endtask

  task automatic test_flush();
    ent_t y;
    clear();
    for (int i = 0; i < 3; i++) begin
      drive(rnd_ent());
      tick();
    end
    drive(mk(1'b0, 32'h0, 32'hDEAD_BEEF, 2'b00, 1'b0));
    wb_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; wb_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if ({level, wb_valid, in_ready} !== {LW'(0), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL flush_state: got lvl %0d v %b r %b, expected 0/0/1", level, wb_valid, in_ready);
    end
    y = mk(1'b1, 32'h55, 32'hCAFE_0001, 2'b01, 1'b0);
    drive(y);
    tick();
    in_valid = 1'b0;
    checks++;
    if (act !== vec(y) || level !== LW'(1)) begin
      errors++;
      $display("FAIL flush_next: got %h lvl %0d, expected %h lvl 1", act, level, vec(y));
    end
  endtask

  task automatic test_async_reset();
    clear();
    for (int i = 0; i < 3; i++) begin
      drive(rnd_ent());
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({wb_valid, level, in_ready} !== {1'b0, LW'(0), 1'b1} || act !== 70'h0) begin
      errors++;
      $display("FAIL async_reset: got v %b lvl %0d r %b data %h, expected 0/0/1/0", wb_valid, level, in_ready, act);
    end
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_random();
    ent_t e;
    logic push, pop, fl;
    int bad = 0;
    clear();
    for (int c = 0; c < 400; c++) begin
      e = rnd_ent();
      if ($urandom_range(0, 2) != 0) drive(e); else in_valid = 1'b0;
      wb_ready = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 39) == 0);
      flush = fl;
      #1;
      checks++;
      if (level !== LW'(q.size()) || wb_valid !== (q.size() != 0) ||
          in_ready !== (q.size() < DEPTH) || (q.size() != 0 && act !== vec(q[0]))) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random_%0d: got lvl %0d head %h, expected lvl %0d head %h", c, level, act,
                   q.size(), (q.size() != 0) ? vec(q[0]) : 70'h0);
      end
      push = in_valid && (q.size() < DEPTH);
      pop  = wb_ready && (q.size() != 0);
      tick();
      if (fl) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
    in_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_flags();
    test_fill_hold();
    test_streaming();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
